// File: rtl/proc_frame_ctrl_pkg.sv
// Shared definitions for the frame controller: state encoding, pixel modes,
// kernel width and the bit layout of the status word.
package proc_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_CONV   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int KERNEL_W = 72;

  localparam int STAT_STATE_LSB = 29;
  localparam int STAT_CFG_ERR   = 28;
  localparam int STAT_BUSY_ERR  = 27;
  localparam int STAT_ABORTED   = 26;
  localparam int STAT_FRAME_LSB = 16;
  localparam int STAT_PIX_LSB   = 0;

  // Convolution needs a full 3x3 neighbourhood, so tiny frames are rejected.
  function automatic logic cfg_valid(input logic [1:0] mode,
                                     input logic [31:0] width,
                                     input logic [31:0] height);
    logic ok;
    ok = 1'b1;
    if (mode == MODE_RSVD) ok = 1'b0;
    if (width == 32'd0 || height == 32'd0) ok = 1'b0;
    if (mode == MODE_CONV && (width < 32'd3 || height < 32'd3)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/proc_frame_ctrl_frame_counter.sv
// Pixel counter with last-pixel detection plus the post-frame drain timer.
module frame_counter
  import proc_frame_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 64,
  parameter int DIM_BITS     = 8
) (
  input  logic                clk_in,
  input  logic                rstn,
  input  logic                clear,
  input  logic                count_en,
  input  logic                drain_en,
  input  logic [DIM_BITS-1:0] width,
  input  logic [DIM_BITS-1:0] height,
  output logic [15:0]         pix_cnt,
  output logic                last_pix,
  output logic                drain_done
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [15:0]   total;
  logic [DW-1:0] drain_cnt;

  assign total      = 16'(32'(width) * 32'(height));
  assign last_pix   = count_en && (pix_cnt == total - 16'd1);
  assign drain_done = drain_en && (drain_cnt == DRAIN_LAST);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pix_cnt <= '0;
    end else if (clear) begin
      pix_cnt <= '0;
    end else if (count_en) begin
      pix_cnt <= pix_cnt + 16'd1;
    end
  end

  // The drain timer only runs while the controller sits in DRAIN.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      drain_cnt <= '0;
    end else if (!drain_en) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/proc_frame_ctrl.sv
// Frame controller: validates and latches configuration, streams one frame of
// pixels to the processing datapath, drains, and reports completion.
module proc_frame_ctrl
  import proc_frame_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 64,
  parameter int DIM_BITS     = 8
) (
  input  logic                clk_in,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          cfg_mode,
  input  logic [KERNEL_W-1:0] cfg_kernel,
  input  logic [DIM_BITS-1:0] cfg_width,
  input  logic [DIM_BITS-1:0] cfg_height,
  input  logic [7:0]          src_pixel,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [7:0]          proc_pixel,
  output logic                proc_valid,
  input  logic                proc_ready,
  output logic [1:0]          proc_mode,
  output logic [KERNEL_W-1:0] proc_kernel,
  output logic                busy,
  output logic                done,
  output logic [31:0]         status
);

  state_t                state;
  logic [1:0]            lat_mode;
  logic [KERNEL_W-1:0]   lat_kernel;
  logic [DIM_BITS-1:0]   lat_width;
  logic [DIM_BITS-1:0]   lat_height;
  logic                  cfg_err;
  logic                  busy_err;
  logic                  aborted;
  logic [7:0]            frame_cnt;
  logic [15:0]           pix_cnt;
  logic                  last_pix;
  logic                  drain_done;
  logic                  in_run;
  logic                  handshake;
  logic                  cfg_ok;
  logic                  abort_hit;

  assign in_run     = (state == ST_RUN);
  assign proc_pixel = src_pixel;
  assign proc_valid = src_valid & in_run;
  assign src_ready  = proc_ready & in_run;
  assign handshake  = proc_valid & proc_ready;
  assign cfg_ok     = cfg_valid(cfg_mode, 32'(cfg_width), 32'(cfg_height));
  assign abort_hit  = abort & busy;

  frame_counter #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .DIM_BITS    (DIM_BITS)
  ) u_frame_counter (
    .clk_in    (clk_in),
    .rstn      (rstn),
    .clear     (state == ST_LOAD),
    .count_en  (handshake),
    .drain_en  (state == ST_DRAIN),
    .width     (lat_width),
    .height    (lat_height),
    .pix_cnt   (pix_cnt),
    .last_pix  (last_pix),
    .drain_done(drain_done)
  );

  // The abort override sits after the case so it beats a same-cycle last pixel.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      lat_mode    <= MODE_BYPASS;
      lat_kernel  <= '0;
      lat_width   <= '0;
      lat_height  <= '0;
      proc_mode   <= MODE_BYPASS;
      proc_kernel <= '0;
      cfg_err     <= 1'b0;
      busy_err    <= 1'b0;
      aborted     <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && state != ST_IDLE) busy_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              lat_mode   <= cfg_mode;
              lat_kernel <= cfg_kernel;
              lat_width  <= cfg_width;
              lat_height <= cfg_height;
              cfg_err    <= 1'b0;
              busy_err   <= 1'b0;
              aborted    <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          proc_mode   <= lat_mode;
          proc_kernel <= lat_kernel;
          state       <= ST_RUN;
        end
        ST_RUN: begin
          if (last_pix) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done && !abort) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (abort_hit) begin
        state   <= ST_DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        aborted <= 1'b1;
      end
    end
  end

  always_comb begin
    status = '0;
    status[STAT_STATE_LSB +: 3] = state;
    status[STAT_CFG_ERR]        = cfg_err;
    status[STAT_BUSY_ERR]       = busy_err;
    status[STAT_ABORTED]        = aborted;
    status[STAT_FRAME_LSB +: 8] = frame_cnt;
    status[STAT_PIX_LSB +: 16]  = pix_cnt;
  end

endmodule
